// File: rtl/branch_decode_pkg.sv
// Shared constants and the decoded-entry layout for the branch-family decoder.
package branch_decode_pkg;

  localparam logic [5:0] PRIMARY_BC = 6'd16;
  localparam logic [5:0] PRIMARY_B  = 6'd18;
  localparam logic [5:0] PRIMARY_XL = 6'd19;

  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;
  localparam logic [9:0] XO_BCTAR = 10'd560;

  localparam int unsigned OPC_B     = 32'd24;
  localparam int unsigned OPC_BC    = 32'd25;
  localparam int unsigned OPC_BCLR  = 32'd26;
  localparam int unsigned OPC_BCCTR = 32'd27;
  localparam int unsigned OPC_BCTAR = 32'd28;

  localparam int unsigned BRANCH_UNIT_ID = 32'd6;

  // KIND_NONE is zero so a cleared FIFO slot decodes to an all-zero opcode.
  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_B     = 3'd1,
    KIND_BC    = 3'd2,
    KIND_BCLR  = 3'd3,
    KIND_BCCTR = 3'd4,
    KIND_BCTAR = 3'd5
  } branch_kind_e;

  typedef struct packed {
    branch_kind_e kind;
    logic [4:0]   bo;
    logic [4:0]   bi;
    logic [1:0]   bh;
    logic         aa;
    logic         lk;
    logic         target_valid;
    logic         reads_ctr;
    logic         writes_ctr;
    logic         reads_lr;
    logic         writes_lr;
    logic         reads_tar;
  } branch_entry_t;

endpackage

// File: rtl/branch_decode_fifo.sv
// Small synchronous FIFO holding decoded branches between decode and the backend.
module branch_decode_fifo #(
  parameter int unsigned dataWidth = 32'd8,
  parameter int unsigned depth     = 32'd4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic [dataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [dataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth   = $clog2(depth);
  localparam int unsigned CountWidth = PtrWidth + 32'd1;

  logic [dataWidth-1:0]  mem_r [depth];
  logic [PtrWidth-1:0]   wr_ptr_r;
  logic [PtrWidth-1:0]   rd_ptr_r;
  logic [CountWidth-1:0] count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full_o    = (count_r == CountWidth'(depth));
  assign empty_o   = (count_r == '0);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign data_o    = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mem_r    <= '{default: '0};
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + PtrWidth'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrWidth'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CountWidth'(1'b1);
        2'b01:   count_r <= count_r - CountWidth'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/branch_format_decoder.sv
// Decode-stage branch decoder: I/B/XL-form branches decoded in the accept cycle
// and queued, with a saturating count of dropped non-branch/invalid instructions.
module branch_format_decoder
  import branch_decode_pkg::*;
#(
  parameter int unsigned addressWidth            = 32'd64,
  parameter int unsigned instructionWidth        = 32'd32,
  parameter int unsigned PidSize                 = 32'd32,
  parameter int unsigned TidSize                 = 32'd64,
  parameter int unsigned instructionCounterWidth = 32'd64,
  parameter int unsigned opcodeSize              = 32'd12,
  parameter int unsigned funcUnitCodeSize        = 32'd3,
  parameter int unsigned BranchUnitID            = BRANCH_UNIT_ID,
  parameter int unsigned fifoDepth               = 32'd4,
  parameter int unsigned invCountWidth           = 32'd16
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic                               is64Bit_o,
  output logic [addressWidth-1:0]            targetAddress_o,
  output logic                               targetValid_o,
  output logic [4:0]                         bo_o,
  output logic [4:0]                         bi_o,
  output logic [1:0]                         bh_o,
  output logic                               aa_o,
  output logic                               lk_o,
  output logic                               readsCtr_o,
  output logic                               writesCtr_o,
  output logic                               readsLr_o,
  output logic                               writesLr_o,
  output logic                               readsTar_o,
  output logic [invCountWidth-1:0]           invalidCount_o
);

  localparam int unsigned DataWidth = 32'd2 * addressWidth + PidSize + TidSize
                                    + instructionCounterWidth + 32'd1 + $bits(branch_entry_t);

  // Instruction bit k in big-endian numbering is instruction_i[31-k].
  logic [5:0]              primary_s;
  logic [9:0]              xo_s;
  logic                    ctr_dec_s;
  logic [addressWidth-1:0] li_disp_s;
  logic [addressWidth-1:0] bd_disp_s;
  logic [addressWidth-1:0] raw_target_s;
  logic [addressWidth-1:0] target_s;
  branch_entry_t           entry_s;
  branch_entry_t           head_s;
  logic                    is_branch_s;
  logic                    accept_s;
  logic                    full_s;
  logic                    empty_s;
  logic [DataWidth-1:0]    push_data_s;
  logic [DataWidth-1:0]    head_data_s;
  logic [invCountWidth-1:0] invalid_count_r;

  assign primary_s = instruction_i[31:26];
  assign xo_s      = instruction_i[10:1];
  assign ctr_dec_s = ~instruction_i[23];
  assign li_disp_s = {{(addressWidth-32'd26){instruction_i[25]}}, instruction_i[25:2], 2'b00};
  assign bd_disp_s = {{(addressWidth-32'd16){instruction_i[15]}}, instruction_i[15:2], 2'b00};

  // Field decode and target computation for the instruction presented this cycle.
  always_comb begin
    entry_s      = '0;
    raw_target_s = '0;
    is_branch_s  = 1'b0;
    case (primary_s)
      PRIMARY_B: begin
        is_branch_s          = 1'b1;
        entry_s.kind         = KIND_B;
        entry_s.aa           = instruction_i[1];
        entry_s.target_valid = 1'b1;
        raw_target_s = instruction_i[1] ? li_disp_s : instructionAddress_i + li_disp_s;
      end
      PRIMARY_BC: begin
        is_branch_s          = 1'b1;
        entry_s.kind         = KIND_BC;
        entry_s.bo           = instruction_i[25:21];
        entry_s.bi           = instruction_i[20:16];
        entry_s.aa           = instruction_i[1];
        entry_s.target_valid = 1'b1;
        entry_s.reads_ctr    = ctr_dec_s;
        entry_s.writes_ctr   = ctr_dec_s;
        raw_target_s = instruction_i[1] ? bd_disp_s : instructionAddress_i + bd_disp_s;
      end
      PRIMARY_XL: begin
        entry_s.bo = instruction_i[25:21];
        entry_s.bi = instruction_i[20:16];
        entry_s.bh = instruction_i[12:11];
        case (xo_s)
          XO_BCLR: begin
            is_branch_s        = 1'b1;
            entry_s.kind       = KIND_BCLR;
            entry_s.reads_lr   = 1'b1;
            entry_s.reads_ctr  = ctr_dec_s;
            entry_s.writes_ctr = ctr_dec_s;
          end
          XO_BCCTR: begin
            // Decrementing CTR while branching through it is not a legal form.
            is_branch_s       = ~ctr_dec_s;
            entry_s.kind      = KIND_BCCTR;
            entry_s.reads_ctr = 1'b1;
          end
          XO_BCTAR: begin
            is_branch_s        = 1'b1;
            entry_s.kind       = KIND_BCTAR;
            entry_s.reads_tar  = 1'b1;
            entry_s.reads_ctr  = ctr_dec_s;
            entry_s.writes_ctr = ctr_dec_s;
          end
          default: is_branch_s = 1'b0;
        endcase
      end
      default: is_branch_s = 1'b0;
    endcase
    entry_s.lk        = instruction_i[0];
    entry_s.writes_lr = instruction_i[0];
  end

  // 32-bit mode clears the upper half of the computed target.
  always_comb begin
    target_s = raw_target_s;
    if (!is64Bit_i) begin
      target_s = {{(addressWidth-32'd32){1'b0}}, raw_target_s[31:0]};
    end else begin
      target_s = raw_target_s;
    end
  end

  assign ready_o     = ~full_s;
  assign valid_o     = ~empty_s;
  assign accept_s    = valid_i && ready_o;
  assign push_data_s = {instructionAddress_i, instructionPid_i, instructionTid_i,
                        instructionMajId_i, is64Bit_i, target_s, entry_s};

  branch_decode_fifo #(
    .dataWidth(DataWidth),
    .depth    (fifoDepth)
  ) u_fifo (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .push_i (accept_s && is_branch_s),
    .data_i (push_data_s),
    .pop_i  (valid_o && ready_i),
    .data_o (head_data_s),
    .full_o (full_s),
    .empty_o(empty_s)
  );

  assign {instructionAddress_o, instPid_o, instTid_o, instMajId_o,
          is64Bit_o, targetAddress_o, head_s} = head_data_s;

  // Map the queued entry kind back to the externally visible opcode code.
  always_comb begin
    opcode_o = '0;
    case (head_s.kind)
      KIND_B:     opcode_o = opcodeSize'(OPC_B);
      KIND_BC:    opcode_o = opcodeSize'(OPC_BC);
      KIND_BCLR:  opcode_o = opcodeSize'(OPC_BCLR);
      KIND_BCCTR: opcode_o = opcodeSize'(OPC_BCCTR);
      KIND_BCTAR: opcode_o = opcodeSize'(OPC_BCTAR);
      default:    opcode_o = '0;
    endcase
  end

  assign functionalUnitType_o = funcUnitCodeSize'(BranchUnitID);
  assign targetValid_o = head_s.target_valid;
  assign bo_o          = head_s.bo;
  assign bi_o          = head_s.bi;
  assign bh_o          = head_s.bh;
  assign aa_o          = head_s.aa;
  assign lk_o          = head_s.lk;
  assign readsCtr_o    = head_s.reads_ctr;
  assign writesCtr_o   = head_s.writes_ctr;
  assign readsLr_o     = head_s.reads_lr;
  assign writesLr_o    = head_s.writes_lr;
  assign readsTar_o    = head_s.reads_tar;

  // Saturating count of accepted instructions that were dropped.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      invalid_count_r <= '0;
    end else if (accept_s && !is_branch_s && (invalid_count_r != '1)) begin
      invalid_count_r <= invalid_count_r + invCountWidth'(1'b1);
    end else begin
      invalid_count_r <= invalid_count_r;
    end
  end

  assign invalidCount_o = invalid_count_r;

endmodule

// File: tb/tb_branch_format_decoder.sv
// Randomized and directed bench for branch_format_decoder against a field-level reference model.
module tb_branch_format_decoder;

  localparam int FIFO_DEPTH = 4;

  logic        clock_i = 1'b0;
  logic        reset_i, valid_i, ready_o, is64Bit_i, valid_o, ready_i;
  logic [31:0] instruction_i;
  logic [63:0] instructionAddress_i;
  logic [31:0] instructionPid_i;
  logic [63:0] instructionTid_i, instructionMajId_i;
  logic [11:0] opcode_o;
  logic [2:0]  functionalUnitType_o;
  logic [63:0] instructionAddress_o, instTid_o, instMajId_o, targetAddress_o;
  logic [31:0] instPid_o;
  logic        is64Bit_o, targetValid_o, aa_o, lk_o;
  logic [4:0]  bo_o, bi_o;
  logic [1:0]  bh_o;
  logic        readsCtr_o, writesCtr_o, readsLr_o, writesLr_o, readsTar_o;
  logic [15:0] invalidCount_o;

  typedef struct {
    bit [63:0] addr, pid, tid, majid, target, opcode, bo, bi, bh;
    bit        is64, tv, aa, lk, rc, wc, rl, wl, rt;
  } exp_t;

  exp_t model_q[$];
  int   model_inv;
  int   check_count = 0;
  int   error_count = 0;

  branch_format_decoder dut (
    .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .instructionAddress_i(instructionAddress_i),
    .is64Bit_i(is64Bit_i), .instructionPid_i(instructionPid_i),
    .instructionTid_i(instructionTid_i), .instructionMajId_i(instructionMajId_i),
    .valid_o(valid_o), .ready_i(ready_i), .opcode_o(opcode_o),
    .functionalUnitType_o(functionalUnitType_o), .instructionAddress_o(instructionAddress_o),
    .instPid_o(instPid_o), .instTid_o(instTid_o), .instMajId_o(instMajId_o),
    .is64Bit_o(is64Bit_o), .targetAddress_o(targetAddress_o), .targetValid_o(targetValid_o),
    .bo_o(bo_o), .bi_o(bi_o), .bh_o(bh_o), .aa_o(aa_o), .lk_o(lk_o),
    .readsCtr_o(readsCtr_o), .writesCtr_o(writesCtr_o), .readsLr_o(readsLr_o),
    .writesLr_o(writesLr_o), .readsTar_o(readsTar_o), .invalidCount_o(invalidCount_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference decode from the architectural field definitions (bit 0 = MSB).
  function automatic bit model_decode(input bit [31:0] ins, input bit [63:0] addr, input bit m64, output exp_t e);
    int unsigned op, xo, bo;
    longint      disp;
    bit          ctr_dec, ok;
    e = '{default: 0};
    op = ins >> 26;
    xo = (ins >> 1) % 1024;
    bo = (ins >> 21) % 32;
    ctr_dec = ((bo / 4) % 2) == 0;
    e.lk = ins[0];
    e.wl = ins[0];
    ok = 1'b1;
    if (op == 18 || op == 16) begin
      e.aa = ins[1];
      e.tv = 1'b1;
      if (op == 18) begin
        e.opcode = 64'd24;
        disp = longint'((ins >> 2) % (1 << 24));
        if (disp >= (1 << 23)) disp -= (1 << 24);
      end else begin
        e.opcode = 64'd25;
        e.bo = 64'(bo);
        e.bi = 64'((ins >> 16) % 32);
        e.rc = ctr_dec;
        e.wc = ctr_dec;
        disp = longint'((ins >> 2) % (1 << 14));
        if (disp >= (1 << 13)) disp -= (1 << 14);
      end
      disp = disp * 4;
      e.target = e.aa ? 64'(disp) : addr + 64'(disp);
    end else if (op == 19 && (xo == 16 || xo == 528 || xo == 560)) begin
      e.bo = 64'(bo);
      e.bi = 64'((ins >> 16) % 32);
      e.bh = 64'((ins >> 11) % 4);
      if (xo == 16) begin
        e.opcode = 64'd26; e.rl = 1'b1; e.rc = ctr_dec; e.wc = ctr_dec;
      end else if (xo == 528) begin
        e.opcode = 64'd27; e.rc = 1'b1; ok = !ctr_dec;
      end else begin
        e.opcode = 64'd28; e.rt = 1'b1; e.rc = ctr_dec; e.wc = ctr_dec;
      end
    end else begin
      ok = 1'b0;
    end
    if (!m64) e.target = e.target & 64'h0000_0000_FFFF_FFFF;
    return ok;
  endfunction

  task automatic compare_head(input exp_t e);
    check_value("opcode", 64'(opcode_o), e.opcode);
    check_value("fu_type", 64'(functionalUnitType_o), 64'd6);
    check_value("target", targetAddress_o, e.target);
    check_value("flags", 64'({targetValid_o, aa_o, lk_o, readsCtr_o, writesCtr_o, readsLr_o, writesLr_o, readsTar_o}),
                64'({e.tv, e.aa, e.lk, e.rc, e.wc, e.rl, e.wl, e.rt}));
    check_value("bo", 64'(bo_o), e.bo);
    check_value("bi", 64'(bi_o), e.bi);
    check_value("bh", 64'(bh_o), e.bh);
    check_value("addr", instructionAddress_o, e.addr);
    check_value("pid", 64'(instPid_o), e.pid);
    check_value("tid", instTid_o, e.tid);
    check_value("majid", instMajId_o, e.majid);
    check_value("is64", 64'(is64Bit_o), 64'(e.is64));
  endtask

  // One clock: check status, drive inputs, advance the model, step to the next negedge.
  task automatic step(input bit v, input bit [31:0] ins, input bit [63:0] addr, input bit m64,
                      input bit rdy, output bit accepted);
    exp_t e;
    check_value("ready_o", 64'(ready_o), 64'(model_q.size() != FIFO_DEPTH));
    check_value("valid_o", 64'(valid_o), 64'(model_q.size() != 0));
    check_value("inv_count", 64'(invalidCount_o), 64'(model_inv));
    valid_i = v; instruction_i = ins; instructionAddress_i = addr; is64Bit_i = m64; ready_i = rdy;
    instructionPid_i = $urandom;
    instructionTid_i = {$urandom, $urandom};
    instructionMajId_i = {$urandom, $urandom};
    if (valid_o && rdy && model_q.size() != 0) begin
      e = model_q.pop_front();
      compare_head(e);
    end
    accepted = v && ready_o;
    if (accepted) begin
      if (model_decode(ins, addr, m64, e)) begin
        e.addr = addr; e.pid = 64'(instructionPid_i); e.tid = instructionTid_i;
        e.majid = instructionMajId_i; e.is64 = m64;
        model_q.push_back(e);
      end else if (model_inv != 65535) begin
        model_inv++;
      end
    end
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  initial begin
    bit          acc;
    bit [31:0]   ins;
    bit [63:0]   addr;
    int          sel, waited;
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; is64Bit_i = 1'b0;
    instruction_i = '0; instructionAddress_i = '0; instructionPid_i = '0;
    instructionTid_i = '0; instructionMajId_i = '0;
    model_inv = 0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    check_value("rst_valid", 64'(valid_o), 64'd0);
    check_value("rst_opcode", 64'(opcode_o), 64'd0);
    check_value("rst_target", targetAddress_o, 64'd0);
    reset_i = 1'b0;
    @(negedge clock_i);
    check_value("rst_ready", 64'(ready_o), 64'd1);

    step(1'b1, 32'h4BFFFFFC, 64'h1000, 1'b1, 1'b1, acc);
    check_value("b_valid", 64'(valid_o), 64'd1);
    check_value("b_opcode", 64'(opcode_o), 64'd24);
    check_value("b_target", targetAddress_o, 64'hFFC);
    check_value("b_spr", 64'({targetValid_o, readsCtr_o, writesCtr_o, readsLr_o, writesLr_o, readsTar_o}), 64'b100000);
    step(1'b1, 32'h42000010, 64'h2000, 1'b1, 1'b1, acc);
    check_value("bc_opcode", 64'(opcode_o), 64'd25);
    check_value("bc_bo", 64'(bo_o), 64'd16);
    check_value("bc_target", targetAddress_o, 64'h2010);
    check_value("bc_ctr", 64'({readsCtr_o, writesCtr_o}), 64'b11);
    step(1'b1, 32'h4E800421, 64'h3000, 1'b1, 1'b1, acc);
    check_value("bcctrl_opcode", 64'(opcode_o), 64'd27);
    check_value("bcctrl_flags", 64'({readsCtr_o, writesCtr_o, writesLr_o, targetValid_o}), 64'b1010);
    step(1'b1, 32'h4E000420, 64'h3004, 1'b1, 1'b1, acc);
    check_value("bad_bcctr_queued", 64'(valid_o), 64'd0);
    check_value("bad_bcctr_inv", 64'(invalidCount_o), 64'd1);
    step(1'b1, 32'h48000008, 64'hFFFF_FFFC, 1'b0, 1'b1, acc);
    check_value("b32_target", targetAddress_o, 64'h4);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, acc);

    // Backpressure: four fill the queue, the fifth waits for the first pop.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'h48000000 + 32'(k * 4), 64'h4000 + 64'(k * 16), 1'b1, 1'b0, acc);
      if (k == 3) check_value("bp_full_ready", 64'(ready_o), 64'd0);
      if (k == 4) check_value("bp_fifth_held", 64'(acc), 64'd0);
    end
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 10) begin
      step(1'b1, 32'h48000010, 64'h4040, 1'b1, 1'b1, acc);
      waited++;
    end
    check_value("bp_fifth_accept_cycle", 64'(waited), 64'd2);
    repeat (6) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, acc);

    // Reset with three queued entries and a valid input on the reset cycle.
    for (int k = 0; k < 3; k++) step(1'b1, 32'h48000100, 64'h5000, 1'b1, 1'b0, acc);
    reset_i = 1'b1; valid_i = 1'b1; instruction_i = 32'h48000004; ready_i = 1'b0;
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0; valid_i = 1'b0;
    model_q.delete();
    model_inv = 0;
    check_value("mid_rst_valid", 64'(valid_o), 64'd0);
    check_value("mid_rst_ready", 64'(ready_o), 64'd1);
    check_value("mid_rst_inv", 64'(invalidCount_o), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      ins = $urandom;
      if (sel < 4) ins[31:26] = 6'd18;
      else if (sel < 7) ins[31:26] = 6'd16;
      else if (sel < 9) begin
        ins[31:26] = 6'd19;
        case ($urandom_range(0, 3))
          0: ins[10:1] = 10'd16;
          1: ins[10:1] = 10'd528;
          2: ins[10:1] = 10'd560;
          default: ins[10:1] = 10'($urandom);
        endcase
      end
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) addr = 64'hFFFF_FFF0 + 64'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, ins, addr, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, acc);
    end
    repeat (6) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b1, acc);
    check_value("final_drained", 64'(valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
